// File: rtl/spike_scheduler_pkg.sv
// Shared constants and FSM state type for the spike scheduler and the spike renderer.
package spike_scheduler_pkg;

  localparam int         NUM_SPIKES = 24;
  localparam int         SPIKE_SIZE = 20;
  localparam logic [9:0] PARK_X     = 10'h3FF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_SPAWN  = 2'd2,
    ST_DONE   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/spike_scheduler_free_slot_finder.sv
// Lowest-index search over the slot valid vector; found is low when every slot is in use.
module free_slot_finder #(
  parameter int N  = 24,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  output logic [IW-1:0] index,
  output logic          found
);

  // priority search: scanning high to low leaves the lowest free index last
  always_comb begin
    index = {IW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      index = valid[i] ? index : IW'(i);
    end
    found = ~(&valid);
  end

endmodule

// File: rtl/spike_scheduler.sv
// Per-frame spike table update: scroll every active slot left, then accept at most one spawn.
module spike_scheduler #(
  parameter int         NUM_SPIKES = spike_scheduler_pkg::NUM_SPIKES,
  parameter logic [9:0] PARK_X     = spike_scheduler_pkg::PARK_X
) (
  input  logic       clk_125MHz,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       scroll_en,
  input  logic [3:0] scroll_speed,
  input  logic       clear,
  input  logic       spawn_valid,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic       spawn_dir,
  output logic       spawn_ready,
  output logic [9:0] SpikeX [0:NUM_SPIKES-1],
  output logic [9:0] SpikeY [0:NUM_SPIKES-1],
  output logic       Draw_direction [0:NUM_SPIKES-1],
  output logic       busy,
  output logic       update_done
);
  import spike_scheduler_pkg::*;

  localparam int IW = $clog2(NUM_SPIKES);

  sched_state_e          state_r;
  sched_state_e          next_state_s;
  logic [IW-1:0]         index_r;
  logic [NUM_SPIKES-1:0] valid_r;
  logic [IW-1:0]         free_idx_s;
  logic                  free_found_s;
  logic                  spawn_go_s;
  logic [9:0]            speed_s;

  free_slot_finder #(.N(NUM_SPIKES), .IW(IW)) u_finder (
    .valid (valid_r),
    .index (free_idx_s),
    .found (free_found_s)
  );

  assign speed_s = {6'd0, scroll_speed};
  // reset and clear both win over a spawn landing on the same edge
  assign spawn_go_s  = (state_r == ST_SPAWN) && spawn_valid && free_found_s && !clear && !reset;
  assign spawn_ready = spawn_go_s;
  assign busy        = (state_r != ST_IDLE);
  assign update_done = (state_r == ST_DONE);

  // next-state decode; frame_start is only looked at in IDLE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:   next_state_s = frame_start ? (scroll_en ? ST_SCROLL : ST_SPAWN) : ST_IDLE;
      ST_SCROLL: next_state_s = (index_r == IW'(NUM_SPIKES - 1)) ? ST_SPAWN : ST_SCROLL;
      ST_SPAWN:  next_state_s = ST_DONE;
      ST_DONE:   next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // FSM state and scroll index
  always_ff @(posedge clk_125MHz) begin
    if (reset || clear) begin
      state_r <= ST_IDLE;
      index_r <= {IW{1'b0}};
    end else begin
      state_r <= next_state_s;
      index_r <= (state_r == ST_SCROLL) ? index_r + IW'(1) : {IW{1'b0}};
    end
  end

  // slot table: one slot scrolled per SCROLL cycle, one load in SPAWN
  always_ff @(posedge clk_125MHz) begin
    if (reset || clear) begin
      valid_r <= {NUM_SPIKES{1'b0}};
      for (int i = 0; i < NUM_SPIKES; i++) begin
        SpikeX[i]         <= PARK_X;
        SpikeY[i]         <= 10'd0;
        Draw_direction[i] <= 1'b0;
      end
    end else if (state_r == ST_SCROLL) begin
      if (valid_r[index_r]) begin
        if (SpikeX[index_r] >= speed_s) begin
          SpikeX[index_r] <= SpikeX[index_r] - speed_s;
        end else begin
          valid_r[index_r]        <= 1'b0;
          SpikeX[index_r]         <= PARK_X;
          SpikeY[index_r]         <= 10'd0;
          Draw_direction[index_r] <= 1'b0;
        end
      end
    end else if (spawn_go_s) begin
      valid_r[free_idx_s]        <= 1'b1;
      SpikeX[free_idx_s]         <= spawn_x;
      SpikeY[free_idx_s]         <= spawn_y;
      Draw_direction[free_idx_s] <= spawn_dir;
    end
  end

endmodule

// File: tb/tb_spike_scheduler.sv
// Scoreboard bench for spike_scheduler: a slot-table model predicts each pass, a monitor checks DUT events.
module tb_spike_scheduler;

  localparam int NS = 24;

  logic       clk_125MHz = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       scroll_en = 1'b0;
  logic [3:0] scroll_speed = 4'd0;
  logic       clear = 1'b0;
  logic       spawn_valid = 1'b0;
  logic [9:0] spawn_x = 10'd0;
  logic [9:0] spawn_y = 10'd0;
  logic       spawn_dir = 1'b0;
  logic       spawn_ready;
  logic [9:0] SpikeX [0:NS-1];
  logic [9:0] SpikeY [0:NS-1];
  logic       Draw_direction [0:NS-1];
  logic       busy;
  logic       update_done;

  spike_scheduler dut (
    .clk_125MHz     (clk_125MHz),
    .reset          (reset),
    .frame_start    (frame_start),
    .scroll_en      (scroll_en),
    .scroll_speed   (scroll_speed),
    .clear          (clear),
    .spawn_valid    (spawn_valid),
    .spawn_x        (spawn_x),
    .spawn_y        (spawn_y),
    .spawn_dir      (spawn_dir),
    .spawn_ready    (spawn_ready),
    .SpikeX         (SpikeX),
    .SpikeY         (SpikeY),
    .Draw_direction (Draw_direction),
    .busy           (busy),
    .update_done    (update_done)
  );

  always #4 clk_125MHz = ~clk_125MHz;

  int cyc = 0;
  always @(posedge clk_125MHz) cyc <= cyc + 1;

  typedef struct packed {
    int               start;
    int               done;
    int               spawn;
    logic [NS-1:0][9:0] x;
    logic [NS-1:0][9:0] y;
    logic [NS-1:0]      d;
  } rec_t;

  rec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference slot table
  bit         mv [NS];
  logic [9:0] mx [NS];
  logic [9:0] my [NS];
  bit         md [NS];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_parked(input string name);
    int bad = -1;
    for (int i = 0; i < NS; i++)
      if (SpikeX[i] != 10'h3FF || SpikeY[i] != 10'd0 || Draw_direction[i] != 1'b0) bad = i;
    chk(name, bad, -1);
  endtask

  task automatic mpark(input int i);
    mv[i] = 1'b0; mx[i] = 10'h3FF; my[i] = 10'd0; md[i] = 1'b0;
  endtask

  task automatic mreset();
    for (int i = 0; i < NS; i++) mpark(i);
  endtask

  task automatic step();
    @(posedge clk_125MHz);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step();
    @(negedge clk_125MHz);
    chk_parked("reset_table");
    chk("reset_busy", busy, 0);
    chk("reset_update_done", update_done, 0);
    chk("reset_spawn_ready", spawn_ready, 0);
    step();
    reset = 1'b0;
    mreset();
  endtask

  // one full pass: predict it, queue the prediction, drive it to completion
  task automatic run_frame(input bit sen, input int spd, input bit sv,
                           input int sx, input int sy, input bit sd, input bit dup);
    rec_t r;
    bit   placed = 1'b0;
    scroll_en = sen; scroll_speed = spd[3:0]; spawn_valid = sv;
    spawn_x = sx[9:0]; spawn_y = sy[9:0]; spawn_dir = sd;
    frame_start = 1'b1;
    if (sen)
      for (int i = 0; i < NS; i++)
        if (mv[i]) begin
          if (int'(mx[i]) >= spd) mx[i] = mx[i] - spd[9:0];
          else mpark(i);
        end
    r.spawn = -1;
    if (sv)
      for (int i = 0; i < NS; i++)
        if (!mv[i] && !placed) begin
          placed = 1'b1;
          mv[i] = 1'b1; mx[i] = sx[9:0]; my[i] = sy[9:0]; md[i] = sd;
          r.spawn = cyc + (sen ? 25 : 1);
        end
    r.start = cyc;
    r.done  = cyc + (sen ? 26 : 2);
    for (int i = 0; i < NS; i++) begin
      r.x[i] = mx[i]; r.y[i] = my[i]; r.d[i] = md[i];
    end
    sb.push_back(r);
    step();
    for (int k = 1; k < (sen ? 28 : 4); k++) begin
      frame_start = (dup && k == 10);
      step();
    end
    frame_start = 1'b0;
    spawn_valid = 1'b0;
  endtask

  // monitor: busy window, spawn_ready timing, update_done timing and final table
  bit   seen_spawn = 1'b0;
  rec_t cur;
  int   bad_slot;
  always @(negedge clk_125MHz) begin
    if (sb.size() > 0)
      chk("busy", busy, (cyc > sb[0].start && cyc <= sb[0].done) ? 1 : 0);
    if (spawn_ready) begin
      if (sb.size() == 0) chk("spawn_ready_unexpected", 1, 0);
      else begin
        chk("spawn_ready_cycle", cyc, sb[0].spawn);
        seen_spawn = 1'b1;
      end
    end
    if (update_done) begin
      if (sb.size() == 0) chk("update_done_unexpected", 1, 0);
      else begin
        cur = sb.pop_front();
        chk("update_done_cycle", cyc, cur.done);
        chk("spawn_accepted", seen_spawn, (cur.spawn >= 0) ? 1 : 0);
        bad_slot = -1;
        for (int i = 0; i < NS; i++)
          if (SpikeX[i] != cur.x[i] || SpikeY[i] != cur.y[i] || Draw_direction[i] != cur.d[i])
            bad_slot = i;
        chk("table_first_bad_slot", bad_slot, -1);
        seen_spawn = 1'b0;
      end
    end
  end

  initial begin
    int c0;
    mreset();
    do_reset();

    // first spawn lands in slot 0 with two-cycle turnaround
    run_frame(1'b0, 0, 1'b1, 600, 400, 1'b1, 1'b0);
    // scroll by 5 with no spawn; busy window and 26-cycle latency
    run_frame(1'b1, 5, 1'b0, 0, 0, 1'b0, 1'b0);
    // zero speed leaves table unchanged; a repeated frame_start mid-pass is ignored
    run_frame(1'b1, 0, 1'b0, 0, 0, 1'b0, 1'b1);

    // expiry and reuse of the lowest free slot
    do_reset();
    run_frame(1'b0, 0, 1'b1, 3, 50, 1'b1, 1'b0);
    run_frame(1'b0, 0, 1'b1, 100, 60, 1'b0, 1'b0);
    run_frame(1'b1, 5, 1'b1, 700, 70, 1'b1, 1'b0);

    // full table: spawn held off until a slot expires
    do_reset();
    for (int i = 0; i < NS; i++)
      run_frame(1'b0, 0, 1'b1, (i == 0) ? 4 : 500 + i, i, i[0], 1'b0);
    for (int f = 0; f < 3; f++)
      run_frame(1'b0, 0, 1'b1, 321, 123, 1'b1, 1'b0);
    run_frame(1'b1, 5, 1'b0, 0, 0, 1'b0, 1'b0);
    run_frame(1'b0, 0, 1'b1, 321, 123, 1'b1, 1'b0);

    // randomized frames, small X values included to force expiries
    do_reset();
    for (int f = 0; f < 40; f++)
      run_frame(1'($urandom % 2), int'($urandom % 16), 1'(($urandom % 4) != 0),
                ($urandom % 3 == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 1000)),
                int'($urandom_range(0, 1023)), 1'($urandom % 2), 1'b0);

    // clear in cycle 12 of SCROLL aborts the pass
    run_frame(1'b0, 0, 1'b1, 800, 10, 1'b1, 1'b0);
    scroll_en = 1'b1; scroll_speed = 4'd1; frame_start = 1'b1;
    c0 = cyc;
    step();
    frame_start = 1'b0;
    while (cyc < c0 + 12) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk_125MHz);
    chk_parked("clear_table");
    chk("clear_busy", busy, 0);
    repeat (30) step();
    mreset();

    // reset during SPAWN: no acceptance, table cleared
    run_frame(1'b0, 0, 1'b1, 900, 20, 1'b0, 1'b0);
    scroll_en = 1'b0; spawn_valid = 1'b1; spawn_x = 10'd77; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    reset = 1'b1;
    @(negedge clk_125MHz);
    chk("reset_mid_spawn_ready", spawn_ready, 0);
    step();
    reset = 1'b0;
    spawn_valid = 1'b0;
    @(negedge clk_125MHz);
    chk_parked("reset_mid_spawn_table");
    chk("reset_mid_spawn_busy", busy, 0);
    repeat (5) step();
    mreset();

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
